// File: rtl/grover_iterate.sv
// grover_iterate -- streaming Grover-iteration engine over a 2^NQ-entry
// amplitude vector.
//
// A run loads N = 2^NQ signed amplitudes, applies num_iter rounds of
// oracle (negate the target entry) followed by diffusion (reflect every
// entry about the mean), then streams the N results back out.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a run when idle (captures target_search, num_iter)
//   target_search     marked basis-state index
//   num_iter          number of Grover iterations (0 = pass-through)
//   in_valid/in_ready/in_data     load stream, index order 0..N-1
//   out_valid/out_ready/out_data  result stream, index order 0..N-1
//   out_last          marks result beat N-1
//   busy              high in every state except IDLE
//
// Build option: define GROVER_SAT_EN to saturate the oracle negation and
// the diffusion result to the AW-bit range; otherwise both wrap.
module grover_iterate #(
    parameter int NQ = 3,
    parameter int AW = 8,
    parameter int IW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NQ-1:0]        target_search,
    input  logic [IW-1:0]        num_iter,
    input  logic                 in_valid,
    input  logic signed [AW-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic signed [AW-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int N = 1 << NQ;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ORACLE, S_MEAN, S_DIFFUSE, S_OUT
    } state_t;

    state_t                  state, state_nxt;
    logic [NQ-1:0]           idx;
    logic [IW-1:0]           iter_cnt;
    logic [IW-1:0]           iter_inc;
    logic [NQ-1:0]           tgt_q;
    logic [IW-1:0]           niter_q;
    logic signed [AW+NQ-1:0] acc;
    logic signed [AW-1:0]    mean;
    logic signed [AW-1:0]    store [N];

    logic                    idx_last;
    logic signed [AW-1:0]    cur;
    logic signed [AW+1:0]    cur_x;
    logic signed [AW+1:0]    neg_x;
    logic signed [AW+1:0]    diff_x;
    logic signed [AW-1:0]    oracle_val;

    // Reduce an AW+2-bit intermediate back to AW bits.
    function automatic logic signed [AW-1:0] reduce(input logic signed [AW+1:0] v);
`ifdef GROVER_SAT_EN
        // In range exactly when the top three bits agree.
        if (v[AW+1:AW-1] == 3'b000 || v[AW+1:AW-1] == 3'b111)
            return v[AW-1:0];
        else if (v[AW+1])
            return {1'b1, {(AW-1){1'b0}}};
        else
            return {1'b0, {(AW-1){1'b1}}};
`else
        return AW'(v);
`endif
    endfunction

    assign idx_last   = (idx == {NQ{1'b1}});
    assign iter_inc   = iter_cnt + IW'(1);
    assign cur        = store[idx];
    assign cur_x      = (AW+2)'(cur);
    assign neg_x      = -cur_x;
    assign diff_x     = ((AW+2)'(mean) <<< 1) - cur_x;
    assign oracle_val = (idx == tgt_q) ? reduce(neg_x) : cur;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:    if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && idx_last)
                    state_nxt = (niter_q != '0) ? S_ORACLE : S_OUT;
            end
            S_ORACLE:  if (idx_last) state_nxt = S_MEAN;
            S_MEAN:    state_nxt = S_DIFFUSE;
            S_DIFFUSE: if (idx_last) state_nxt = (iter_inc == niter_q) ? S_OUT : S_ORACLE;
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = cur;
                out_last  = idx_last;
                if (out_ready && idx_last) state_nxt = S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Control/datapath registers. idx is NQ bits wide, so it wraps back to
    // 0 on its own after entry N-1, ready for the next phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            iter_cnt <= '0;
            acc      <= '0;
            mean     <= '0;
            tgt_q    <= '0;
            niter_q  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    tgt_q    <= target_search;
                    niter_q  <= num_iter;
                    idx      <= '0;
                    iter_cnt <= '0;
                    acc      <= '0;
                end
                S_LOAD:    if (in_valid) idx <= idx + NQ'(1);
                S_ORACLE: begin
                    idx <= idx + NQ'(1);
                    acc <= acc + (AW+NQ)'(oracle_val);
                end
                S_MEAN: begin
                    // Arithmetic shift gives floor division by N.
                    mean <= AW'(acc >>> NQ);
                    acc  <= '0;
                end
                S_DIFFUSE: begin
                    idx <= idx + NQ'(1);
                    if (idx_last) iter_cnt <= iter_inc;
                end
                S_OUT:     if (out_ready) idx <= idx + NQ'(1);
                default: ;
            endcase
        end
    end

    // Amplitude store: no reset, every run reloads all N entries.
    always_ff @(posedge clk) begin
        case (state)
            S_LOAD:    if (in_valid) store[idx] <= in_data;
            S_ORACLE:  store[idx] <= oracle_val;
            S_DIFFUSE: store[idx] <= reduce(diff_x);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_grover_iterate.sv
module tb_grover_iterate;
    localparam int NQ = 3;
    localparam int AW = 8;
    localparam int IW = 4;
    localparam int N  = 8;

    typedef logic [N-1:0][AW-1:0] vec_t;
    typedef struct {
        vec_t a;
        int   tgt;
        int   ni;
        vec_t exp;
        int   busy_exp;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NQ-1:0] target_search = '0;
    logic [IW-1:0] num_iter = '0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic          busy;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    grover_iterate #(.NQ(NQ), .AW(AW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .target_search(target_search),
        .num_iter(num_iter), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .busy(busy)
    );

    task automatic chk(input string nm, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    function automatic int wrap8(input int x);
        int m;
        m = (x + 128) % 256;
        if (m < 0) m += 256;
        return m - 128;
    endfunction

    function automatic int red(input int x);
`ifdef GROVER_SAT_EN
        if (x > 127)  return 127;
        if (x < -128) return -128;
        return x;
`else
        return wrap8(x);
`endif
    endfunction

    // Reference: Grover iteration on plain integers.
    function automatic vec_t model(input vec_t a, input int tgt, input int ni);
        int   v [N];
        int   s, m;
        vec_t r;
        for (int i = 0; i < N; i++) v[i] = int'($signed(a[i]));
        for (int it = 0; it < ni; it++) begin
            v[tgt] = red(-v[tgt]);
            s = 0;
            for (int i = 0; i < N; i++) s += v[i];
            m = s / N;
            if (s < 0 && (s % N) != 0) m--;
            m = wrap8(m);
            for (int i = 0; i < N; i++) v[i] = red(2 * m - v[i]);
        end
        for (int i = 0; i < N; i++) r[i] = 8'(v[i]);
        return r;
    endfunction

    function automatic vec_t splat(input int x);
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = 8'(x);
        return r;
    endfunction

    // mode 0: in_valid and out_ready held high
    // mode 1: out_ready toggles, start pulsed mid-run with other inputs
    // mode 2: random in_valid and out_ready
    // abort_at > 0: assert rst once busy has been seen that many cycles
    task automatic do_run(input vec_t a, input int tgt, input int ni, input int mode,
                          input int abort_at, output vec_t r, output int nbusy);
        int   k, beats, cyc;
        logic pv, pr, ordy;
        logic [AW-1:0] pd;
        k = 0; beats = 0; cyc = 0; nbusy = 0;
        pv = 1'b0; pr = 1'b0; pd = '0; r = '0;
        @(negedge clk);
        target_search = NQ'(tgt);
        num_iter      = IW'(ni);
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (beats < N && cyc < 500) begin
            if (busy) nbusy++;
            if (abort_at > 0 && nbusy == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_mid_busy", int'(busy), 0);
                chk("rst_mid_out_valid", int'(out_valid), 0);
                chk("rst_mid_in_ready", int'(in_ready), 0);
                chk("rst_mid_out_last", int'(out_last), 0);
                chk("rst_mid_out_data", int'(out_data), 0);
                in_valid = 1'b0;
                out_ready = 1'b0;
                return;
            end
            if (pv && !pr)
                chk("hold", int'({out_valid, out_data}), int'({1'b1, pd}));
            if (mode == 1 && nbusy >= 10 && nbusy <= 12) begin
                start = 1'b1;
                target_search = NQ'(tgt + 2);
                num_iter = IW'(ni + 5);
            end else begin
                start = 1'b0;
            end
            in_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = (k < N) ? a[k] : '0;
            if (in_ready && in_valid) k++;
            ordy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            out_ready = ordy;
            if (out_valid) begin
                chk($sformatf("last_b%0d", beats), int'(out_last), int'(beats == N - 1));
                if (ordy) begin
                    r[beats] = out_data;
                    beats++;
                end
            end
            pv = out_valid; pr = ordy; pd = out_data;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 500) chk("timeout", cyc, -1);
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("idle_after_run", int'(busy), 0);
    endtask

    rec_t tbl [4];
    vec_t res, exp_v, va;
    int   nb;

    initial begin
        tbl[0].a = splat(32); tbl[0].tgt = 3; tbl[0].ni = 1;
        tbl[0].exp = splat(16); tbl[0].exp[3] = 8'd80; tbl[0].busy_exp = 33;
        tbl[1].a = splat(32); tbl[1].tgt = 3; tbl[1].ni = 2;
        tbl[1].exp = splat(-8); tbl[1].exp[3] = 8'd88; tbl[1].busy_exp = 50;
        for (int i = 0; i < N; i++) tbl[2].a[i] = 8'(i + 1);
        tbl[2].tgt = 3; tbl[2].ni = 0; tbl[2].exp = tbl[2].a; tbl[2].busy_exp = 16;
        tbl[3].a = splat(-128); tbl[3].tgt = 0; tbl[3].ni = 1; tbl[3].busy_exp = 33;
`ifdef GROVER_SAT_EN
        tbl[3].exp = splat(-66); tbl[3].exp[0] = 8'h80;
`else
        tbl[3].exp = splat(-128);
`endif

        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_last", int'(out_last), 0);
        chk("reset_out_data", int'(out_data), 0);
        rst = 1'b0;

        for (int t = 0; t < 4; t++) begin
            do_run(tbl[t].a, tbl[t].tgt, tbl[t].ni, 0, 0, res, nb);
            chk($sformatf("vec%0d_busy", t), nb, tbl[t].busy_exp);
            for (int i = 0; i < N; i++)
                chk($sformatf("vec%0d_b%0d", t, i),
                    int'($signed(res[i])), int'($signed(tbl[t].exp[i])));
        end

        // Back-pressure with start pulses while busy.
        do_run(tbl[0].a, 3, 1, 1, 0, res, nb);
        for (int i = 0; i < N; i++)
            chk($sformatf("toggle_b%0d", i), int'($signed(res[i])), int'($signed(tbl[0].exp[i])));

        // Reset in DIFFUSE (busy cycle 20), then a clean rerun.
        do_run(tbl[0].a, 3, 1, 0, 20, res, nb);
        do_run(tbl[0].a, 3, 1, 0, 0, res, nb);
        chk("rerun_busy", nb, 33);
        for (int i = 0; i < N; i++)
            chk($sformatf("rerun_b%0d", i), int'($signed(res[i])), int'($signed(tbl[0].exp[i])));

        // Randomized runs against the reference model.
        for (int t = 0; t < 12; t++) begin
            int tg, ni;
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       va[i] = 8'h80;
                    1:       va[i] = 8'h7f;
                    default: va[i] = 8'($urandom);
                endcase
            end
            tg = int'($urandom_range(0, N - 1));
            ni = int'($urandom_range(0, 3));
            exp_v = model(va, tg, ni);
            do_run(va, tg, ni, 2, 0, res, nb);
            for (int i = 0; i < N; i++)
                chk($sformatf("rand%0d_b%0d", t, i), int'($signed(res[i])), int'($signed(exp_v[i])));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
